// File: rtl/tone_direction_decoder_pkg.sv
// Shared encodings for the tone decoder and the drive state machine that consumes td_dir.
// Also holds the command decode used to validate one window's presence flags.
package tone_direction_decoder_pkg;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 5;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_CONFIRM    = 2'b01,
        ST_VALID      = 2'b10,
        ST_WAIT_CLEAR = 2'b11
    } state_t;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } cmd_t;

    // Junction tone (bit 4) plus exactly one direction tone makes a command.
    function automatic cmd_t decode_cmd(input logic [NUM_CH-1:0] present);
        cmd_t c;
        c.vld = present[4];
        c.dir = DIR_STRAIGHT;
        case (present[3:0])
            4'b0001: c.dir = DIR_STRAIGHT;
            4'b0010: c.dir = DIR_LEFT;
            4'b0100: c.dir = DIR_RIGHT;
            4'b1000: c.dir = DIR_BACK;
            default: c.vld = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tone_direction_decoder_if.sv
// Comparator inputs, command acknowledge and the level-valid command/status outputs.
// slave = decoder side, master = drive logic / comparator side.
interface tone_direction_decoder_if;
    import tone_direction_decoder_pkg::*;

    logic [NUM_CH-1:0] bp;
    logic              td_ack;
    logic              td_en;
    dir_t              td_dir;
    logic [NUM_CH-1:0] tone_present;

    modport master (output bp, td_ack, input td_en, td_dir, tone_present);
    modport slave  (input bp, td_ack, output td_en, td_dir, tone_present);

endinterface

// File: rtl/tone_channel_meter.sv
// One comparator channel: synchronizer, rising-edge detect, saturating per-window edge count.
// Latency: pin to counted edge 3 cycles; no backpressure, present is valid on the tick cycle.
module tone_channel_meter
    import tone_direction_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bp,
    input  logic             tick,
    input  logic [CNT_W-1:0] min_edges,
    output logic             present
);

    logic             sync1_q, sync2_q, dly_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        rise    = sync2_q & ~dly_q;
        cnt_inc = (rise && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        // The tick cycle's own edge still belongs to the closing window.
        present = (cnt_inc >= min_edges);
        cnt_d   = tick ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= bp;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_direction_decoder.sv
// Qualifies five tone channels per window and confirms one direction over consecutive windows.
// Latency: td_en rises at the edge closing the confirming tick; no backpressure, td_ack only consumes.
module tone_direction_decoder
    import tone_direction_decoder_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 500_000,
    parameter int MIN_EDGES       = 8,
    parameter int CONFIRM_WINDOWS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tone_direction_decoder_if.slave bus
);

    localparam int         WIN_W       = $clog2(WINDOW_CYCLES);
    localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_WINDOWS);

    logic [WIN_W-1:0]  win_q, win_d;
    logic              tick;
    logic [NUM_CH-1:0] present;
    logic [NUM_CH-1:0] tone_present_q, tone_present_d;
    cmd_t              cmd;
    logic [3:0]        agree_q, agree_nxt;
    state_t            state_q;
    dir_t              cand_q, td_dir_q;
    logic              td_en_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_meter
        tone_channel_meter u_meter (
            .clk       (clk),
            .rst_n     (rst_n),
            .bp        (bus.bp[i]),
            .tick      (tick),
            .min_edges (CNT_W'(MIN_EDGES)),
            .present   (present[i])
        );
    end

    always_comb begin
        tick           = (win_q == WIN_W'(WINDOW_CYCLES - 1));
        win_d          = tick ? '0 : win_q + WIN_W'(1);
        tone_present_d = tick ? present : tone_present_q;
        cmd            = decode_cmd(present);
        agree_nxt      = agree_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q          <= '0;
            tone_present_q <= '0;
        end else begin
            win_q          <= win_d;
            tone_present_q <= tone_present_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cand_q   <= DIR_STRAIGHT;
            agree_q  <= 4'd0;
            td_en_q  <= 1'b0;
            td_dir_q <= DIR_STRAIGHT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && cmd.vld) begin
                        cand_q  <= cmd.dir;
                        agree_q <= 4'd1;
                        if (CONFIRM_WINDOWS == 1) begin
                            state_q  <= ST_VALID;
                            td_en_q  <= 1'b1;
                            td_dir_q <= cmd.dir;
                        end else begin
                            state_q <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (tick) begin
                        if (!cmd.vld) begin
                            state_q <= ST_IDLE;
                        end else if (cmd.dir == cand_q) begin
                            agree_q <= agree_nxt;
                            if (agree_nxt >= CONFIRM_TGT) begin
                                state_q  <= ST_VALID;
                                td_en_q  <= 1'b1;
                                td_dir_q <= cand_q;
                            end
                        end else begin
                            cand_q  <= cmd.dir;
                            agree_q <= 4'd1;
                        end
                    end
                end
                ST_VALID: begin
                    // Acknowledge outranks a same-cycle tick so a consumed burst is never re-armed.
                    if (bus.td_ack) begin
                        state_q <= ST_WAIT_CLEAR;
                        td_en_q <= 1'b0;
                    end else if (tick && (!cmd.vld || (cmd.dir != td_dir_q))) begin
                        state_q <= ST_IDLE;
                        td_en_q <= 1'b0;
                    end
                end
                ST_WAIT_CLEAR: begin
                    if (tick && !cmd.vld) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.td_en        = td_en_q;
    assign bus.td_dir       = td_dir_q;
    assign bus.tone_present = tone_present_q;

endmodule

// File: tb/tb_tone_direction_decoder.sv
// Directed scenarios against a window/streak model of the decoder, compared every cycle.
module tb_tone_direction_decoder;
    import tone_direction_decoder_pkg::*;

    localparam int WIN  = 100;
    localparam int MINE = 4;
    localparam int CONF = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_direction_decoder_if bus_if ();

    tone_direction_decoder #(
        .WINDOW_CYCLES   (WIN),
        .MIN_EDGES       (MINE),
        .CONFIRM_WINDOWS (CONF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int shown  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (shown < 40) begin
                shown++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // Tone sources: channel i toggles every per_ch[i]/2 cycles, 0 = silent.
    int         per_ch[5];
    int         tc = 0;
    logic [4:0] bp_v;
    always @(negedge clk) begin
        tc++;
        for (int i = 0; i < 5; i++)
            bp_v[i] = (per_ch[i] == 0) ? 1'b0 : (((tc / (per_ch[i] / 2)) % 2) == 1);
        bus_if.bp = bp_v;
    end

    // Model: count edges per window, then track a streak of identical valid windows.
    int         k;
    int         cnt[5];
    logic [4:0] h1, h2, h3, m_e, m_p, pres_m;
    int         m_ones, streak;
    logic       m_vld, m_tick, consumed, en_m;
    logic [1:0] m_dir, sdir, dir_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; h1 = 0; h2 = 0; h3 = 0; pres_m = 0;
            streak = 0; sdir = 0; dir_m = 0; consumed = 0; en_m = 0;
            for (int i = 0; i < 5; i++) cnt[i] = 0;
        end else begin
            k++;
            m_tick = (k % WIN == 0);
            m_e = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = bus_if.bp;
            for (int i = 0; i < 5; i++)
                if (m_e[i]) cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
            m_vld = 0; m_dir = 0; m_p = 0;
            if (m_tick) begin
                m_ones = 0;
                for (int i = 0; i < 5; i++) m_p[i] = (cnt[i] >= MINE);
                for (int i = 0; i < 4; i++)
                    if (m_p[i]) begin m_ones++; m_dir = 2'(i); end
                m_vld = m_p[4] && (m_ones == 1);
            end
            if (en_m && bus_if.td_ack) begin
                consumed = 1;
            end else if (m_tick) begin
                if (consumed) begin
                    if (!m_vld) begin consumed = 0; streak = 0; end
                end else if (streak >= CONF) begin
                    if (m_vld && m_dir == sdir) streak++; else streak = 0;
                end else if (!m_vld) begin
                    streak = 0;
                end else if (streak > 0 && m_dir == sdir) begin
                    streak++;
                end else begin
                    streak = 1; sdir = m_dir;
                end
                if (!consumed && streak == CONF) dir_m = sdir;
            end
            if (m_tick) begin
                pres_m = m_p;
                for (int i = 0; i < 5; i++) cnt[i] = 0;
            end
            en_m = !consumed && (streak >= CONF);
        end
    end

    bit cmp_on    = 0;
    int right_cnt = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("td_en", 32'(bus_if.td_en), 32'(en_m));
            chk("td_dir", 32'(bus_if.td_dir), 32'(dir_m));
            chk("tone_present", 32'(bus_if.tone_present), 32'(pres_m));
            if (bus_if.td_dir == DIR_RIGHT) right_cnt++;
        end
    end

    task automatic tones(input int p0, input int p1, input int p2, input int p3, input int p4);
        per_ch[0] = p0; per_ch[1] = p1; per_ch[2] = p2; per_ch[3] = p3; per_ch[4] = p4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_to(input int t);
        int guard;
        guard = 0;
        while (k < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k < t) chk("wait_timeout", 32'(k), 32'(t));
    endtask

    task automatic pulse_ack();
        bus_if.td_ack = 1'b1;
        @(negedge clk);
        bus_if.td_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int base_right;

    initial begin
        bus_if.td_ack = 1'b0;
        bus_if.bp     = '0;
        tones(0, 0, 0, 0, 0);

        // Reset state and LEFT detection on the third window.
        tones(0, 10, 0, 0, 10);
        do_reset();
        chk("rst_td_en", 32'(bus_if.td_en), 32'd0);
        chk("rst_td_dir", 32'(bus_if.td_dir), 32'd0);
        chk("rst_present", 32'(bus_if.tone_present), 32'd0);
        cmp_on = 1;
        wait_to(100);
        chk("s1_present", 32'(bus_if.tone_present), 32'b10010);
        chk("s1_en_tick1", 32'(bus_if.td_en), 32'd0);
        wait_to(299);
        chk("s1_en_before_tick3", 32'(bus_if.td_en), 32'd0);
        wait_to(300);
        chk("s1_en_tick3", 32'(bus_if.td_en), 32'd1);
        chk("s1_dir", 32'(bus_if.td_dir), 32'b01);

        // Two direction tones, then too few edges.
        tones(10, 0, 10, 0, 10);
        do_reset();
        wait_to(100);
        chk("s2_present", 32'(bus_if.tone_present), 32'b10101);
        wait_to(400);
        chk("s2_en_ambiguous", 32'(bus_if.td_en), 32'd0);
        tones(0, 0, 34, 0, 34);
        wait_to(900);
        chk("s2_present_weak", 32'(bus_if.tone_present), 32'b00000);
        chk("s2_en_weak", 32'(bus_if.td_en), 32'd0);

        // Acknowledge, gap window, re-detection.
        tones(0, 10, 0, 0, 10);
        do_reset();
        wait_to(300);
        chk("s3_en_valid", 32'(bus_if.td_en), 32'd1);
        wait_to(330);
        pulse_ack();
        chk("s3_en_after_ack", 32'(bus_if.td_en), 32'd0);
        wait_to(400);
        chk("s3_en_wait_clear", 32'(bus_if.td_en), 32'd0);
        tones(0, 0, 0, 0, 0);
        wait_to(500);
        tones(0, 10, 0, 0, 10);
        wait_to(799);
        chk("s3_en_before_redetect", 32'(bus_if.td_en), 32'd0);
        wait_to(800);
        chk("s3_en_redetect", 32'(bus_if.td_en), 32'd1);

        // Candidate change restarts confirmation; then loss and ack-on-tick.
        tones(0, 0, 10, 0, 10);
        do_reset();
        base_right = right_cnt;
        wait_to(200);
        tones(0, 0, 0, 10, 10);
        wait_to(499);
        chk("s4_en_before_tick5", 32'(bus_if.td_en), 32'd0);
        wait_to(500);
        chk("s4_en_tick5", 32'(bus_if.td_en), 32'd1);
        chk("s4_dir_back", 32'(bus_if.td_dir), 32'b11);
        chk("s4_never_right", 32'(right_cnt - base_right), 32'd0);
        wait_to(510);
        tones(0, 0, 0, 10, 0);
        wait_to(599);
        chk("s5_en_before_loss", 32'(bus_if.td_en), 32'd1);
        wait_to(600);
        chk("s5_en_loss", 32'(bus_if.td_en), 32'd0);
        tones(0, 0, 0, 10, 10);
        wait_to(900);
        chk("s5_en_reconfirm", 32'(bus_if.td_en), 32'd1);
        wait_to(999);
        pulse_ack();
        chk("s5_ack_on_tick", 32'(bus_if.td_en), 32'd0);
        wait_to(1100);
        chk("s5_wait_clear_holds", 32'(bus_if.td_en), 32'd0);

        // Fast toggling channel, then reset in the middle of VALID.
        tones(2, 0, 0, 0, 10);
        do_reset();
        wait_to(100);
        chk("s6_present_fast", 32'(bus_if.tone_present), 32'b10001);
        wait_to(300);
        chk("s6_en_valid", 32'(bus_if.td_en), 32'd1);
        chk("s6_dir", 32'(bus_if.td_dir), 32'b00);
        wait_to(350);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_en", 32'(bus_if.td_en), 32'd0);
        chk("s6_rst_present", 32'(bus_if.tone_present), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_to(299);
        chk("s6_en_before_redetect", 32'(bus_if.td_en), 32'd0);
        wait_to(300);
        chk("s6_en_redetect", 32'(bus_if.td_en), 32'd1);

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_direction_decoder.md
# tone_direction_decoder

Tone-detection front end feeding the drive state machine's JUNCTION handling. It qualifies five band-pass comparator outputs (bp1..bp5) over fixed measurement windows and confirms a single direction command across consecutive windows. It then presents the command as `td_en`/`td_dir`, the level-valid pair consumed by the drive logic. An acknowledge input prevents one tone burst from being executed twice.

## Interface
- `WINDOW_CYCLES`, 500_000: measurement window length in clk cycles (10 ms at 50 MHz); legal range ≥ 16.
- `MIN_EDGES`, 8: rising edges per window required to declare a channel present; 1..255.
- `CONFIRM_WINDOWS`, 3: consecutive agreeing windows required before `td_en` asserts; 1..15.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `bp1`..`bp4`  in  1 each  asynchronous comparator outputs for direction tones: STRAIGHT, LEFT, RIGHT, BACK.
- `bp5`  in  1  asynchronous comparator output for the junction qualifier tone.
- `td_ack`  in  1  single-cycle pulse from the drive logic: command consumed.
- `td_en`  out  1  direction command valid (level).
- `td_dir`  out  2  command: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK; valid only while `td_en`=1.
- `tone_present`  out  5  per-window presence flags, bit i-1 = bp_i, for status/debug.

## Operation
- Each bp input passes through a 2-flop synchronizer plus 1 delay flop; rising edge = synced & ~delayed.
- Per-channel 8-bit edge counter, saturating at 255, cleared at each window start.
- Free-running window counter 0..WINDOW_CYCLES-1. "Tick" = the cycle where the counter equals WINDOW_CYCLES-1. An edge on the tick cycle counts toward the closing window.
- At tick, present[i] = (count_i ≥ MIN_EDGES).
- A command is valid when present[4]=1 and exactly one of present[3:0]=1. The direction is that bit's encoding.
- FSM states are IDLE, CONFIRM, VALID, WAIT_CLEAR. Transitions are evaluated only at tick, except for `td_ack`.
  - IDLE: valid cmd → CONFIRM with cand=cmd, agree=1. If CONFIRM_WINDOWS=1, go straight to VALID.
  - CONFIRM, valid cmd equal to cand: agree+1. When agree reaches CONFIRM_WINDOWS → VALID, latch `td_dir`=cand.
  - CONFIRM, valid cmd different from cand: stay in CONFIRM, cand=new, agree=1.
  - CONFIRM, invalid cmd: → IDLE.
  - VALID: `td_en`=1. `td_ack` (any cycle) → WAIT_CLEAR. At tick, an invalid or different cmd → IDLE (tone lost before consumption).
  - WAIT_CLEAR: `td_en`=0. The first tick with invalid cmd → IDLE. A persisting valid cmd keeps the FSM here.
- Simultaneous `td_ack` and tick in VALID: ack wins, → WAIT_CLEAR.
- `td_ack` outside VALID: ignored.
- `td_dir` holds its last value when `td_en`=0. It changes only on entry to VALID.

## Timing
- Reset (async assert, synchronous release on `clk`): state IDLE, `td_en`=0, `td_dir`=00, `tone_present`=00000, all counters and synchronizers 0.
- Reset mid-operation: immediate return to the reset values above. The window restarts from 0 after release.
- Pin-to-edge-detect latency: 3 cycles.
- `tone_present` updates at the clock edge closing the tick cycle and holds for the whole next window.
- `td_en` rises at the clock edge closing the tick of the CONFIRM_WINDOWS-th agreeing window.
- `td_en` falls at the clock edge closing a cycle with `td_ack`=1, or closing a tick with loss/change of the tone.
- Window counter wraps WINDOW_CYCLES-1 → 0 with no dead cycle.

## Structure
- Shared package holds:
  - direction encodings STRAIGHT/LEFT/RIGHT/BACK (2'b00..2'b11), shared with the drive state machine;
  - FSM state encodings;
  - an edge-count width constant (8).
- Sub-module `tone_channel_meter`, instantiated 5×, contains the synchronizer, edge detect and saturating counter. Inputs are `clk`, `rst_n`, `bp`, tick and `MIN_EDGES`; output is the present flag.
- The top level holds the window counter, command validation and the FSM.

## Test plan
All scenarios use WINDOW_CYCLES=100, MIN_EDGES=4, CONFIRM_WINDOWS=3.
- bp2 and bp5 toggling with a 10-cycle period → `tone_present`=5'b10010 after the first tick. `td_en`=1 and `td_dir`=01 at the third tick, not before.
- bp1, bp3 and bp5 all active → `tone_present`=5'b10101, `td_en` never asserts. bp3 and bp5 at 3 edges/window → `td_en` never asserts.
- VALID with tone continuing, `td_ack` pulse → `td_en`=0 next cycle and stays 0. Stop the tone for one window, restart it → `td_en` reasserts 3 windows later.
- Two windows of bp3+bp5, then bp4+bp5 → confirm restarts. `td_dir`=11 at the 5th tick, never 10.
- In VALID, drop bp5 → `td_en` falls at the next tick. `td_ack` coincident with the tick → WAIT_CLEAR.
- Toggle bp1 every cycle (≈50 edges) → counter shows no overflow and channel present. Assert `rst_n`=0 mid-VALID → `td_en`=0 and `tone_present`=0 immediately, re-detection takes 3 full windows.
